// File: rtl/picture_pointer_array.sv
// picture_pointer_array: address generator for the convolution datapath.
// Holds N_UNITS parallel picture pointers. Together they walk a dilated K x K
// kernel window over a row-major image. Unit i addresses the output pixel that
// is offset horizontally by i from unit 0. Each step advances all units by one
// kernel tap, in row-major tap order.
module picture_pointer_array #(
    parameter int N_UNITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [31:0]        start_addr,
    input  logic [7:0]         kernel_size,
    input  logic [7:0]         dilation,
    input  logic [15:0]        width,
    input  logic [N_UNITS-1:0] active_units,
    output logic [31:0]        addr_out [N_UNITS-1:0]
);

    // Tap position inside the window: column c and row r.
    logic [7:0]  c_q, c_d;
    logic [7:0]  r_q, r_d;

    // Index of the last tap along one axis. K = 0 and K = 1 both collapse to a
    // single tap, so the counters never leave zero.
    logic [7:0]  k_last;

    // Address offsets, each formed at full product width.
    logic [15:0] row_taps;   // r * D
    logic [31:0] row_off;    // r * D * W
    logic [15:0] col_off;    // c * D

    assign k_last = (kernel_size == 8'd0) ? 8'd0 : kernel_size - 8'd1;

    // Next tap position. The >= compares make a mid-walk shrink of the kernel
    // wrap cleanly on the next step instead of running past the new edge.
    always_comb begin
        // NOTE: default every output first so that no path holds a stale value,
        // which would infer a latch.
        c_d = c_q;
        r_d = r_q;
        if (step) begin
            if (c_q >= k_last) begin
                c_d = 8'd0;
                if (r_q >= k_last) begin
                    r_d = 8'd0;
                end else begin
                    r_d = r_q + 8'd1;
                end
            end else begin
                c_d = c_q + 8'd1;
            end
        end
    end

    // Tap counters. Reset wins over step.
    always_ff @(posedge clk) begin
        // NOTE: this reset is synchronous. rst is sampled only on the clock edge.
        // Every state register here uses non-blocking assignments, so all of
        // them update together at the edge.
        if (rst) begin
            c_q <= 8'd0;
            r_q <= 8'd0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

    // Shared offsets. All units sit on the same tap, so they share these offsets.
    always_comb begin
        row_taps = r_q * dilation;
        row_off  = row_taps * width;
        col_off  = c_q * dilation;
    end

    // Per-unit address, computed from the live config. The sum wraps modulo 2^32.
    // Units that are not enabled output zero.
    always_comb begin
        for (int i = 0; i < N_UNITS; i++) begin
            addr_out[i] = '0;
            if (active_units[i]) begin
                addr_out[i] = start_addr + 32'(i) + row_off + {16'd0, col_off};
            end
        end
    end

endmodule

// File: tb/tb_picture_pointer_array.sv
// Self-checking bench for picture_pointer_array (N_UNITS = 4).
// A table of vectors covers reset, the column walk, the row wrap and dilation.
// Hand-written sequences cover priority, hold, held step, degenerate kernels,
// a kernel shrink mid-walk, wide products and wrap modulo 2^32.
module tb_picture_pointer_array;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           step;
    logic [31:0]    start_addr;
    logic [7:0]     kernel_size;
    logic [7:0]     dilation;
    logic [15:0]    width;
    logic [N-1:0]   active_units;
    logic [31:0]    addr_out [N-1:0];

    picture_pointer_array #(.N_UNITS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .step         (step),
        .start_addr   (start_addr),
        .kernel_size  (kernel_size),
        .dilation     (dilation),
        .width        (width),
        .active_units (active_units),
        .addr_out     (addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [N-1:0][31:0] addr_vec_t;

    typedef struct {
        string       name;
        logic [31:0] start;
        logic [7:0]  k;
        logic [7:0]  d;
        logic [15:0] w;
        logic [3:0]  mask;
        logic        stp;
        logic        rs;
        addr_vec_t   exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;
    addr_vec_t exp_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", nm, act, act, req, req);
    endtask

    // Pop one expectation and compare it against every lane.
    task automatic compare(input string nm);
        addr_vec_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) check($sformatf("%s.u%0d", nm, i), addr_out[i], e[i]);
        end
    endtask

    // Drive step/rst, then check the result after the next rising edge.
    task automatic run(input logic s, input logic r, input addr_vec_t e, input string nm);
        step = s;
        rst  = r;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare(nm);
    endtask

    // Check the combinational response to a config change, with no clock edge.
    task automatic check_now(input addr_vec_t e, input string nm);
        exp_q.push_back(e);
        #1;
        compare(nm);
    endtask

    // Reference model: the tap index counts steps since reset.
    function automatic addr_vec_t model(input int tap, input logic [31:0] s, input int k,
                                        input int d, input int w, input logic [3:0] m);
        addr_vec_t v;
        int kk, c, r;
        longint a;
        kk = (k < 2) ? 1 : k;
        c  = tap % kk;
        r  = (tap / kk) % kk;
        for (int i = 0; i < N; i++) begin
            a    = longint'(s) + i + longint'(r) * d * w + longint'(c) * d;
            v[i] = m[i] ? a[31:0] : 32'd0;
        end
        return v;
    endfunction

    task automatic set_cfg(input logic [31:0] s, input logic [7:0] k, input logic [7:0] d,
                           input logic [15:0] w, input logic [3:0] m);
        start_addr   = s;
        kernel_size  = k;
        dilation     = d;
        width        = w;
        active_units = m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"reset",   100, 4, 1, 6,  4'b1011, 0, 1, {32'd103, 32'd0, 32'd101, 32'd100}};
        vecs[1] = '{"col1",    100, 4, 1, 6,  4'b1011, 1, 0, {32'd104, 32'd0, 32'd102, 32'd101}};
        vecs[2] = '{"col2",    100, 4, 1, 6,  4'b1011, 1, 0, {32'd105, 32'd0, 32'd103, 32'd102}};
        vecs[3] = '{"col3",    100, 4, 1, 6,  4'b1011, 1, 0, {32'd106, 32'd0, 32'd104, 32'd103}};
        vecs[4] = '{"rowwrap", 100, 4, 1, 6,  4'b1011, 1, 0, {32'd109, 32'd0, 32'd107, 32'd106}};
        vecs[5] = '{"dil_rst", 0,   3, 2, 10, 4'b1111, 0, 1, {32'd3,   32'd2,  32'd1,  32'd0}};
        vecs[6] = '{"dil1",    0,   3, 2, 10, 4'b1111, 1, 0, {32'd5,   32'd4,  32'd3,  32'd2}};
        vecs[7] = '{"dil2",    0,   3, 2, 10, 4'b1111, 1, 0, {32'd7,   32'd6,  32'd5,  32'd4}};
        vecs[8] = '{"dil3",    0,   3, 2, 10, 4'b1111, 1, 0, {32'd23,  32'd22, 32'd21, 32'd20}};
        vecs[9] = '{"dil4",    0,   3, 2, 10, 4'b1111, 1, 0, {32'd25,  32'd24, 32'd23, 32'd22}};

        set_cfg(100, 4, 1, 6, 4'b1011);
        step = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset, column walk and first row wrap.
        for (int v = 0; v < 5; v++) begin
            set_cfg(vecs[v].start, vecs[v].k, vecs[v].d, vecs[v].w, vecs[v].mask);
            run(vecs[v].stp, vecs[v].rs, vecs[v].exp, vecs[v].name);
        end
        // The rest of the 16-tap window, ending back at tap (0,0).
        for (int t = 5; t <= 16; t++)
            run(1, 0, model(t, 100, 4, 1, 6, 4'b1011), $sformatf("walk%0d", t));

        // Dilation walk.
        for (int v = 5; v < 10; v++) begin
            set_cfg(vecs[v].start, vecs[v].k, vecs[v].d, vecs[v].w, vecs[v].mask);
            run(vecs[v].stp, vecs[v].rs, vecs[v].exp, vecs[v].name);
        end

        // Reset has priority over a step in the same cycle.
        run(1, 1, model(0, 0, 3, 2, 10, 4'b1111), "rst_prio");
        run(1, 0, model(1, 0, 3, 2, 10, 4'b1111), "pre_hold");
        for (int h = 0; h < 5; h++)
            run(0, 0, model(1, 0, 3, 2, 10, 4'b1111), $sformatf("hold%0d", h));
        // Step held high for three consecutive edges advances three taps.
        for (int t = 2; t <= 4; t++)
            run(1, 0, model(t, 0, 3, 2, 10, 4'b1111), $sformatf("held%0d", t));

        // Degenerate kernels K = 0 and K = 1 stay on the single tap.
        set_cfg(50, 0, 3, 7, 4'b1111);
        run(0, 1, {32'd53, 32'd52, 32'd51, 32'd50}, "k0_rst");
        for (int t = 0; t < 3; t++) run(1, 0, {32'd53, 32'd52, 32'd51, 32'd50}, $sformatf("k0_s%0d", t));
        kernel_size = 8'd1;
        for (int t = 0; t < 3; t++) run(1, 0, {32'd53, 32'd52, 32'd51, 32'd50}, $sformatf("k1_s%0d", t));

        // Shrinking K mid-walk: at c = 3 with K reduced to 2, the walk wraps to the next row.
        set_cfg(100, 4, 1, 6, 4'b1111);
        run(0, 1, model(0, 100, 4, 1, 6, 4'b1111), "shr_rst");
        for (int t = 1; t <= 3; t++) run(1, 0, model(t, 100, 4, 1, 6, 4'b1111), $sformatf("shr_w%0d", t));
        kernel_size = 8'd2;
        run(1, 0, {32'd109, 32'd108, 32'd107, 32'd106}, "shr_row");
        run(1, 0, {32'd110, 32'd109, 32'd108, 32'd107}, "shr_col");
        run(1, 0, {32'd103, 32'd102, 32'd101, 32'd100}, "shr_wrap");

        // Full-width products: r*D*W = 255*65535 at tap (0,1).
        set_cfg(0, 3, 255, 16'hFFFF, 4'b1111);
        run(0, 1, model(0, 0, 3, 255, 65535, 4'b1111), "wide_rst");
        for (int t = 1; t <= 4; t++) run(1, 0, model(t, 0, 3, 255, 65535, 4'b1111), $sformatf("wide%0d", t));
        run(0, 0, {32'd16711428 + 32'd255, 32'd16711427 + 32'd255, 32'd16711426 + 32'd255, 32'd16711425 + 32'd255}, "wide_lit");

        // D = 0 aliases every tap to start_addr + i.
        set_cfg(7, 3, 0, 9, 4'b1111);
        run(1, 0, {32'd10, 32'd9, 32'd8, 32'd7}, "d0");

        // Wrap modulo 2^32, plus a live mask change with no clock edge.
        set_cfg(32'hFFFF_FFFF, 4, 1, 6, 4'b1111);
        run(0, 1, {32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF}, "wrap32");
        active_units = 4'b0101;
        check_now({32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF}, "live_mask");
        start_addr = 32'd1000;
        check_now({32'd0, 32'd1002, 32'd0, 32'd1000}, "live_start");

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: %0d expectations left over", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
